// File: rtl/sccb_responder.sv
// SCCB/I2C target with a 256x8 register file; every accepted write byte is
// echoed on a one-clk strobe so configuration traffic can be observed.
`timescale 1ns/1ps
module sccb_responder #(
  parameter logic [6:0] DEV_ADDR   = 7'h21,
  parameter logic [7:0] RESET_FILL = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_drive_low,
  output logic       reg_wr_strobe,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_DEV_ADDR, ST_DEV_ACK, ST_REG_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_IGNORE
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] sclSync_q, sdaSync_q;
  logic [2:0] bitCnt_q, bitCnt_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] ptr_q, ptr_d;
  logic [7:0] wrAddr_q, wrAddr_d;
  logic [7:0] wrData_q, wrData_d;
  logic       rw_q, rw_d;
  logic       sdaLow_q, sdaLow_d;
  logic       strobe_q, strobe_d;
  logic       busy_q, busy_d;
  logic       memWe;
  logic [7:0] mem_q [256];

  logic       scl, sclPrev, sda, sdaPrev;
  logic       sclRise, sclFall, startEv, stopEv, lastRise;
  logic [7:0] rxByte, ptrData;

  // Synchronisers idle high so reset release never fakes a bus edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclSync_q <= '1;
      sdaSync_q <= '1;
    end else begin
      sclSync_q <= {sclSync_q[1:0], scl_in};
      sdaSync_q <= {sdaSync_q[1:0], sda_in};
    end
  end

  assign scl      = sclSync_q[1];
  assign sclPrev  = sclSync_q[2];
  assign sda      = sdaSync_q[1];
  assign sdaPrev  = sdaSync_q[2];
  assign sclRise  = scl & ~sclPrev;
  assign sclFall  = ~scl & sclPrev;
  assign startEv  = scl & sclPrev & sdaPrev & ~sda;
  assign stopEv   = scl & sclPrev & ~sdaPrev & sda;
  assign lastRise = sclRise && (bitCnt_q == 3'd7);
  assign rxByte   = {shift_q[6:0], sda};
  assign ptrData  = mem_q[ptr_q];

  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    ptr_d    = ptr_q;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    rw_d     = rw_q;
    sdaLow_d = sdaLow_q;
    strobe_d = 1'b0;
    busy_d   = busy_q;
    memWe    = 1'b0;
    if (stopEv) begin
      state_d  = ST_IDLE;
      sdaLow_d = 1'b0;
      busy_d   = 1'b0;
    end else if (startEv) begin
      state_d  = ST_DEV_ADDR;
      bitCnt_d = 3'd0;
      sdaLow_d = 1'b0;
    end else begin
      case (state_q)
        ST_DEV_ADDR, ST_REG_PTR, ST_WDATA: begin
          if (sclRise) begin
            shift_d  = rxByte;
            bitCnt_d = bitCnt_q + 3'd1;
          end
          if (lastRise) begin
            if (state_q == ST_DEV_ADDR) begin
              if (rxByte[7:1] == DEV_ADDR) begin
                state_d = ST_DEV_ACK;
                rw_d    = rxByte[0];
                busy_d  = 1'b1;
              end else begin
                state_d = ST_IGNORE;
                busy_d  = 1'b0;
              end
            end else if (state_q == ST_REG_PTR) begin
              ptr_d   = rxByte;
              state_d = ST_PTR_ACK;
            end else begin
              memWe    = 1'b1;
              strobe_d = 1'b1;
              wrAddr_d = ptr_q;
              wrData_d = rxByte;
              ptr_d    = ptr_q + 8'd1;
              state_d  = ST_WDATA_ACK;
            end
          end
        end
        // First fall after bit 8 starts the ACK, the next one ends it.
        ST_DEV_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (sclFall) begin
            if (!sdaLow_q) begin
              sdaLow_d = 1'b1;
            end else begin
              sdaLow_d = 1'b0;
              bitCnt_d = 3'd0;
              if (state_q == ST_DEV_ACK && rw_q) begin
                state_d  = ST_RDATA;
                shift_d  = ptrData;
                sdaLow_d = ~ptrData[7];
              end else if (state_q == ST_DEV_ACK) begin
                state_d = ST_REG_PTR;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (sclRise) begin
            bitCnt_d = bitCnt_q + 3'd1;
          end else if (sclFall) begin
            if (bitCnt_q == 3'd0) begin
              sdaLow_d = 1'b0;
              ptr_d    = ptr_q + 8'd1;
              state_d  = ST_RDATA_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sdaLow_d = ~shift_q[6];
            end
          end
        end
        // bitCnt = 1 marks an initiator ACK still waiting for its SCL fall.
        ST_RDATA_ACK: begin
          if (sclRise) begin
            if (sda) state_d = ST_IGNORE;
            else     bitCnt_d = 3'd1;
          end else if (sclFall && bitCnt_q == 3'd1) begin
            state_d  = ST_RDATA;
            bitCnt_d = 3'd0;
            shift_d  = ptrData;
            sdaLow_d = ~ptrData[7];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      bitCnt_q <= 3'd0;
      shift_q  <= 8'd0;
      ptr_q    <= 8'd0;
      wrAddr_q <= 8'd0;
      wrData_q <= 8'd0;
      rw_q     <= 1'b0;
      sdaLow_q <= 1'b0;
      strobe_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
      ptr_q    <= ptr_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      rw_q     <= rw_d;
      sdaLow_q <= sdaLow_d;
      strobe_q <= strobe_d;
      busy_q   <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem_q[i] <= RESET_FILL;
    end else if (memWe) begin
      mem_q[ptr_q] <= rxByte;
    end
  end

  assign sda_drive_low = sdaLow_q;
  assign reg_wr_strobe = strobe_q;
  assign reg_wr_addr   = wrAddr_q;
  assign reg_wr_data   = wrData_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_sccb_responder.sv
// Directed bench for sccb_responder: the bench plays the bus initiator with a
// wired-AND SDA line and checks ACKs, read data, strobes and busy.
`timescale 1ns/1ps
module tb_sccb_responder;

  localparam int Q = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       sclM, sdaM;
  logic       sdaLine;
  logic       sda_drive_low, reg_wr_strobe, busy;
  logic [7:0] reg_wr_addr, reg_wr_data;

  int         checks = 0;
  int         errors = 0;
  int         strobeCount = 0;
  int         driveCount = 0;
  logic [7:0] strobeAddr [16];
  logic [7:0] strobeData [16];

  always #10 clk = ~clk;

  assign sdaLine = sdaM & ~sda_drive_low;

  sccb_responder dut (
    .clk(clk), .reset(reset), .scl_in(sclM), .sda_in(sdaLine),
    .sda_drive_low(sda_drive_low), .reg_wr_strobe(reg_wr_strobe),
    .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data), .busy(busy)
  );

  // Log every strobe cycle and every cycle the responder pulls SDA.
  always @(negedge clk) begin
    if (reg_wr_strobe) begin
      if (strobeCount < 16) begin
        strobeAddr[strobeCount] = reg_wr_addr;
        strobeData[strobeCount] = reg_wr_data;
      end
      strobeCount++;
    end
    if (sda_drive_low) driveCount++;
  end

  function automatic logic [7:0] getAddr(input int idx);
    return (idx >= 0 && idx < 16) ? strobeAddr[idx] : 8'hxx;
  endfunction

  function automatic logic [7:0] getData(input int idx);
    return (idx >= 0 && idx < 16) ? strobeData[idx] : 8'hxx;
  endfunction

  task automatic applyStimulus(input logic sclLvl, input logic sdaLvl);
    sclM = sclLvl;
    sdaM = sdaLvl;
    #(Q * 20);
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic startCond();
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic stopCond();
    applyStimulus(1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1);
  endtask

  task automatic clockBit(input logic b, output logic sampled);
    applyStimulus(1'b0, b);
    applyStimulus(1'b1, b);
    sampled = sdaLine;
    applyStimulus(1'b1, b);
    applyStimulus(1'b0, b);
  endtask

  task automatic sendByte(input logic [7:0] b, output logic ackLvl);
    logic dummy;
    for (int i = 7; i >= 0; i--) clockBit(b[i], dummy);
    clockBit(1'b1, ackLvl);
  endtask

  task automatic readByte(input logic masterAck, output logic [7:0] d);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clockBit(1'b1, s);
      d[i] = s;
    end
    clockBit(masterAck, s);
  endtask

  initial begin
    logic       ack, ackA, ackB, ackC;
    logic       dummy;
    logic [7:0] d;
    int         s0, d0;

    reset = 1'b0;
    sclM  = 1'b1;
    sdaM  = 1'b1;
    #105;
    checkOutput("rst_drive", {7'd0, sda_drive_low}, 8'h00);
    checkOutput("rst_busy", {7'd0, busy}, 8'h00);
    checkOutput("rst_strobe", {7'd0, reg_wr_strobe}, 8'h00);
    checkOutput("rst_addr", reg_wr_addr, 8'h00);
    checkOutput("rst_data", reg_wr_data, 8'h00);
    reset = 1'b1;
    #200;

    // Test 1: fresh register file reads back the fill value
    startCond();
    sendByte(8'h42, ack);  checkOutput("t1_ack_w", {7'd0, ack}, 8'h00);
    sendByte(8'h12, ack);
    startCond();
    sendByte(8'h43, ack);  checkOutput("t1_ack_r", {7'd0, ack}, 8'h00);
    readByte(1'b1, d);     checkOutput("t1_rd12", d, 8'h00);
    stopCond();

    // Test 2: single write
    s0 = strobeCount;
    startCond();
    sendByte(8'h42, ackA);
    checkOutput("t2_busy_on", {7'd0, busy}, 8'h01);
    sendByte(8'h12, ackB);
    sendByte(8'h80, ackC);
    stopCond();
    checkOutput("t2_ack_dev", {7'd0, ackA}, 8'h00);
    checkOutput("t2_ack_ptr", {7'd0, ackB}, 8'h00);
    checkOutput("t2_ack_dat", {7'd0, ackC}, 8'h00);
    checkOutput("t2_nstrobe", 8'(strobeCount - s0), 8'd1);
    checkOutput("t2_saddr", getAddr(s0), 8'h12);
    checkOutput("t2_sdata", getData(s0), 8'h80);
    checkOutput("t2_busy_off", {7'd0, busy}, 8'h00);

    // Test 3: pointer wrap across 0xFF
    s0 = strobeCount;
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'hFE, ack);
    sendByte(8'h11, ack);
    sendByte(8'h22, ack);
    sendByte(8'h33, ack);
    stopCond();
    checkOutput("t3_nstrobe", 8'(strobeCount - s0), 8'd3);
    checkOutput("t3_saddr0", getAddr(s0), 8'hFE);
    checkOutput("t3_saddr1", getAddr(s0 + 1), 8'hFF);
    checkOutput("t3_saddr2", getAddr(s0 + 2), 8'h00);
    checkOutput("t3_sdata2", getData(s0 + 2), 8'h33);
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'hFE, ack);
    startCond();
    sendByte(8'h43, ack);
    readByte(1'b0, d);     checkOutput("t3_rdFE", d, 8'h11);
    readByte(1'b0, d);     checkOutput("t3_rdFF", d, 8'h22);
    readByte(1'b1, d);     checkOutput("t3_rd00", d, 8'h33);
    stopCond();

    // Test 4: repeated-start read of two consecutive registers
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'h13, ack);
    sendByte(8'hC3, ack);
    stopCond();
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'h12, ack);
    startCond();
    sendByte(8'h43, ack);
    readByte(1'b0, d);     checkOutput("t4_rd12", d, 8'h80);
    readByte(1'b1, d);     checkOutput("t4_rd13", d, 8'hC3);
    checkOutput("t4_released", {7'd0, sda_drive_low}, 8'h00);
    stopCond();
    checkOutput("t4_busy_off", {7'd0, busy}, 8'h00);

    // Test 5: foreign address is never acknowledged
    s0 = strobeCount;
    d0 = driveCount;
    startCond();
    sendByte(8'h60, ack);  checkOutput("t5_nack", {7'd0, ack}, 8'h01);
    checkOutput("t5_busy", {7'd0, busy}, 8'h00);
    sendByte(8'h12, ack);
    sendByte(8'h34, ack);
    stopCond();
    checkOutput("t5_nstrobe", 8'(strobeCount - s0), 8'd0);
    checkOutput("t5_ndrive", 8'(driveCount - d0), 8'd0);

    // Test 6: START aborts a data byte, then reset lands during an ACK
    s0 = strobeCount;
    startCond();
    sendByte(8'h42, ack);
    sendByte(8'h30, ack);
    clockBit(1'b1, dummy);
    clockBit(1'b0, dummy);
    clockBit(1'b1, dummy);
    clockBit(1'b0, dummy);
    startCond();
    for (int i = 7; i >= 0; i--) clockBit(d0 >= 0 ? (8'h42 >> i) & 8'h01 : 1'b0, dummy);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t6_ack_on", {7'd0, sda_drive_low}, 8'h01);
    checkOutput("t6_nstrobe", 8'(strobeCount - s0), 8'd0);
    reset = 1'b0;
    #20;
    checkOutput("t6_rst_drive", {7'd0, sda_drive_low}, 8'h00);
    checkOutput("t6_rst_busy", {7'd0, busy}, 8'h00);
    reset = 1'b1;
    #200;
    stopCond();
    startCond();
    sendByte(8'h42, ack);  checkOutput("t6_idle_ack", {7'd0, ack}, 8'h00);
    sendByte(8'h12, ack);
    startCond();
    sendByte(8'h43, ack);
    readByte(1'b1, d);     checkOutput("t6_rd12", d, 8'h00);
    stopCond();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sccb_responder.md
Name: sccb_responder

Overview:
- I2C/SCCB target (responder) that answers the camera/VGA-encoder configuration initiators on a shared scl/sda pair.
- Holds a 256x8 register file. Supports write (register pointer plus data bytes, auto-increment) and read (current-pointer and repeated-start).
- Serves as the bench/board stand-in for the OV7670 and the VGA encoder. Exposes every completed register write on a strobe bus, so configuration sequences can be checked in-system.

Parameters:
- DEV_ADDR, 7'h21, 7-bit target address matched after START.
- RESET_FILL, 8'h00, reset value of every register-file entry.

Ports:
- clk  input  1  system clock (clk_50); all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- scl_in  input  1  bus SCL level (asynchronous to clk).
- sda_in  input  1  bus SDA level (asynchronous to clk).
- sda_drive_low  output  1  1 = pull SDA low (open-drain); 0 = release.
- reg_wr_strobe  output  1  one-clk pulse per accepted data byte.
- reg_wr_addr  output  8  register written on strobe.
- reg_wr_data  output  8  byte written on strobe.
- busy  output  1  1 from address match until STOP or unaddressed.

Behaviour:
- **Synchronisation and event detection**
  - scl_in and sda_in each pass a 2-FF synchroniser plus one history stage.
  - Edge and condition events come from the last two synchronised samples:
    - START: SDA falls while SCL is high.
    - STOP: SDA rises while SCL is high.
    - scl_rise, scl_fall: edges of synchronised SCL.
  - Bus-to-action latency: 3-4 clk.
- **Reset (reset = 0, async)**
  - State = IDLE; sda_drive_low = 0; reg_wr_strobe = 0; reg_wr_addr = 0; reg_wr_data = 0; busy = 0.
  - Register pointer = 0; all registers = RESET_FILL.
- **State machine**: IDLE, DEV_ADDR, DEV_ACK, REG_PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK, IGNORE.
- **Bit shifting**
  - Bits shift in MSB-first on scl_rise.
  - A 3-bit counter wraps at 8 and selects the following ACK state.
- **DEV_ADDR**
  - After 8 bits, if byte[7:1] == DEV_ADDR: go to DEV_ACK and latch R/W = byte[0]; busy = 1.
  - Otherwise go to IGNORE and never drive SDA.
- **ACK states (DEV_ACK, PTR_ACK, WDATA_ACK)**
  - sda_drive_low = 1 from the scl_fall after bit 8 until the next scl_fall (the 9th clock).
  - Successor after DEV_ACK: R/W = 0 -> REG_PTR; R/W = 1 -> RDATA.
- **REG_PTR**: the received byte loads the pointer; then PTR_ACK -> WDATA.
- **WDATA**
  - Each byte: regs[ptr] <= byte.
  - One-clk pulse on reg_wr_strobe with reg_wr_addr = ptr and reg_wr_data = byte, asserted on the clk after the 8th scl_rise.
  - ptr <= ptr + 1, wrapping 8'hFF -> 8'h00.
  - Then WDATA_ACK -> WDATA.
- **RDATA**
  - regs[ptr] is loaded into the shift register on entry.
  - Each bit: sda_drive_low = ~bit, updated on scl_fall, held through scl high.
  - After 8 bits: release SDA, increment ptr (with wrap), go to RDATA_ACK.
- **RDATA_ACK**
  - Sample SDA on scl_rise.
  - Sampled 0 (ACK) -> RDATA with the next byte.
  - Sampled 1 (NACK) -> IGNORE, SDA released.
- **IGNORE**: wait for START or STOP only.
- **Priority**: START or STOP overrides all states, including mid-byte and during ACK.
  - STOP: go to IDLE, release SDA, busy = 0.
  - START (includes repeated START): go to DEV_ADDR, reset the bit counter, release SDA. ptr is preserved, so a write-pointer then repeated-START-read returns regs[ptr].
- **SCCB compatibility**: an initiator that ignores the ACK bit is fine, because the responder ACKs regardless.
- **Reset mid-transfer**: returns immediately to the reset state; the bus is released within 1 clk.
- **Write with no data byte** (pointer then STOP): only the pointer changes, no strobe.

Test Plan:
1. Reset low -> sda_drive_low = 0, busy = 0, strobe = 0. A read of reg 8'h12 afterwards returns RESET_FILL (8'h00).
2. Write 0x42(W), ptr 0x12, data 0x80, STOP -> 3 ACKs low on 9th clocks; one strobe with addr = 0x12, data = 0x80; busy back to 0 after STOP.
3. Write ptr 0xFE then data 0x11, 0x22, 0x33 -> strobes at 0xFE, 0xFF, 0x00 (wrap); a readback from 0xFE gives 0x11, 0x22, 0x33.
4. Write ptr 0x12 then repeated START, 0x43(R), master ACK then NACK -> SDA bits 0x80 then regs[0x13]; SDA released after NACK; STOP -> IDLE.
5. Address 0x60(W) then bytes -> no ACK, no strobe, sda_drive_low stays 0 throughout, busy = 0.
6. START after 4 bits of a data byte, then reset asserted during an ACK -> the aborted byte is not written; SDA releases within 1 clk of reset; state returns to IDLE.
